lane_sched_1a2: RTL and testbench

LANE_SCHED_1A2 -- requirements
Module: lane_sched_1a2

---
 rtl/lane_sched_pkg.sv | 13 +
 rtl/lane_sched_1a2_credit_cnt.sv | 36 +++
 rtl/lane_sched_1a2.sv | 122 ++++++++++++
 tb/tb_lane_sched_1a2.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lane_sched_pkg.sv
// Shared definitions for the two-lane credit scheduler: FSM encoding and credit defaults.
package lane_sched_pkg;

    localparam int CREDITS_DEFAULT = 4;
    localparam int CNT_W           = 3;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/lane_sched_1a2_credit_cnt.sv
// Per-lane saturating credit counter; flags a return that arrives when already full.
module lane_credit_cnt
    import lane_sched_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDITS);

    logic [CNT_W-1:0] r_count;

    // A simultaneous take and return cancel out; a lone return at the limit saturates.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CREDIT_MAX;
        end else if (i_inc && !i_dec && (r_count != CREDIT_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_overflow = i_inc && !i_dec && !i_load && (r_count == CREDIT_MAX);

endmodule

// File: rtl/lane_sched_1a2.sv
// Two-lane word scheduler with per-lane downstream credits, strict or work-conserving.
module lane_sched_1a2
    import lane_sched_pkg::*;
#(
    parameter int DW      = 4,
    parameter int CREDITS = CREDITS_DEFAULT
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic          valid,
    input  logic [DW-1:0] data_in,
    output logic          ready_in,
    input  logic          mode,
    input  logic          pause,
    input  logic          credit_ret0,
    input  logic          credit_ret1,
    output logic          validout0,
    output logic          validout1,
    output logic [DW-1:0] dataout0,
    output logic [DW-1:0] dataout1,
    output logic          lane_ptr,
    output logic          err_credit
);

    sched_state_t     r_state;
    sched_state_t     w_nextState;
    logic             r_lanePtr;
    logic             r_validOut0;
    logic             r_validOut1;
    logic [DW-1:0]    r_dataOut0;
    logic [DW-1:0]    r_dataOut1;
    logic             r_errCredit;

    logic [CNT_W-1:0] w_credit0;
    logic [CNT_W-1:0] w_credit1;
    logic             w_overflow0;
    logic             w_overflow1;
    logic             w_credPtrOk;
    logic             w_credOtherOk;
    logic             w_target;
    logic             w_accept;
    logic             w_load;

    assign w_credPtrOk   = r_lanePtr ? (w_credit1 != '0) : (w_credit0 != '0);
    assign w_credOtherOk = r_lanePtr ? (w_credit0 != '0) : (w_credit1 != '0);

    assign ready_in = (r_state == RUN) && (mode ? (w_credPtrOk || w_credOtherOk) : w_credPtrOk);
    assign w_accept = valid && ready_in;
    assign w_target = (mode && !w_credPtrOk && w_credOtherOk) ? ~r_lanePtr : r_lanePtr;
    assign w_load   = (r_state == INIT);

    lane_credit_cnt #(.CREDITS(CREDITS)) u_credit0 (
        .i_clk      (clk_2f),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_dec      (w_accept && !w_target),
        .i_inc      (credit_ret0),
        .o_count    (w_credit0),
        .o_overflow (w_overflow0)
    );

    lane_credit_cnt #(.CREDITS(CREDITS)) u_credit1 (
        .i_clk      (clk_2f),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_dec      (w_accept && w_target),
        .i_inc      (credit_ret1),
        .o_count    (w_credit1),
        .o_overflow (w_overflow1)
    );

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            INIT:    w_nextState = RUN;
            RUN:     if (pause)  w_nextState = PAUSE;
            PAUSE:   if (!pause) w_nextState = RUN;
            default: w_nextState = INIT;
        endcase
    end

    // Reset wins over a same-edge acceptance, so an in-flight word never pulses out.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            r_lanePtr   <= 1'b0;
            r_validOut0 <= 1'b0;
            r_validOut1 <= 1'b0;
            r_dataOut0  <= '0;
            r_dataOut1  <= '0;
            r_errCredit <= 1'b0;
        end else begin
            r_validOut0 <= w_accept && !w_target;
            r_validOut1 <= w_accept && w_target;
            if (w_accept && !w_target) begin
                r_dataOut0 <= data_in;
            end
            if (w_accept && w_target) begin
                r_dataOut1 <= data_in;
            end
            if (w_accept) begin
                r_lanePtr <= ~w_target;
            end
            r_errCredit <= r_errCredit || w_overflow0 || w_overflow1;
        end
    end

    assign validout0  = r_validOut0;
    assign validout1  = r_validOut1;
    assign dataout0   = r_dataOut0;
    assign dataout1   = r_dataOut1;
    assign lane_ptr   = r_lanePtr;
    assign err_credit = r_errCredit;

endmodule

// File: tb/tb_lane_sched_1a2.sv
// Randomized bench for lane_sched_1a2 against a behavioural model of the scheduling rules.
module tb_lane_sched_1a2;

    localparam int DW      = 4;
    localparam int CREDITS = 4;

    logic          clk_2f = 1'b0;
    logic          reset;
    logic          valid;
    logic [DW-1:0] data_in;
    logic          ready_in;
    logic          mode;
    logic          pause;
    logic          credit_ret0;
    logic          credit_ret1;
    logic          validout0;
    logic          validout1;
    logic [DW-1:0] dataout0;
    logic [DW-1:0] dataout1;
    logic          lane_ptr;
    logic          err_credit;

    int testsRun = 0;
    int testsFailed = 0;

    // Model: phase 0=init 1=run 2=pause, credits as plain integers.
    int            mPhase;
    int            mCredit[2];
    int            mPtr;
    bit            mErr;
    bit            mVo[2];
    logic [DW-1:0] mDo[2];

    lane_sched_1a2 #(.DW(DW), .CREDITS(CREDITS)) dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .valid       (valid),
        .data_in     (data_in),
        .ready_in    (ready_in),
        .mode        (mode),
        .pause       (pause),
        .credit_ret0 (credit_ret0),
        .credit_ret1 (credit_ret1),
        .validout0   (validout0),
        .validout1   (validout1),
        .dataout0    (dataout0),
        .dataout1    (dataout1),
        .lane_ptr    (lane_ptr),
        .err_credit  (err_credit)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase     = 0;
        mCredit[0] = 0;
        mCredit[1] = 0;
        mPtr       = 0;
        mErr       = 1'b0;
        mVo[0]     = 1'b0;
        mVo[1]     = 1'b0;
        mDo[0]     = '0;
        mDo[1]     = '0;
    endtask

    // One clock cycle: drive, check ready, advance model, then check registered outputs.
    task automatic applyStimulus(input bit rst, input bit v, input logic [DW-1:0] d, input bit m,
                                 input bit p, input bit c0, input bit c1, output bit accOut);
        bit rdy;
        bit acc;
        int tgt;
        bit ret[2];
        bit dec[2];
        reset       = rst;
        valid       = v;
        data_in     = d;
        mode        = m;
        pause       = p;
        credit_ret0 = c0;
        credit_ret1 = c1;
        #1;
        rdy = (mPhase == 1) && (m ? (mCredit[0] > 0 || mCredit[1] > 0) : (mCredit[mPtr] > 0));
        checkOutput("ready_in", 32'(ready_in), 32'(rdy));
        acc = v && rdy;
        tgt = mPtr;
        if (m && mCredit[mPtr] == 0 && mCredit[1 - mPtr] > 0) tgt = 1 - mPtr;
        if (rst) begin
            modelReset();
            acc = 1'b0;
        end else begin
            mVo[0] = 1'b0;
            mVo[1] = 1'b0;
            if (acc) begin
                mVo[tgt] = 1'b1;
                mDo[tgt] = d;
            end
            ret[0] = c0;
            ret[1] = c1;
            for (int n = 0; n < 2; n++) begin
                dec[n] = acc && (tgt == n);
                if (mPhase == 0) begin
                    mCredit[n] = CREDITS;
                end else if (ret[n] && !dec[n] && mCredit[n] == CREDITS) begin
                    mErr = 1'b1;
                end else begin
                    mCredit[n] = mCredit[n] + int'(ret[n]) - int'(dec[n]);
                end
            end
            if (acc) mPtr = 1 - tgt;
            if (mPhase == 0)           mPhase = 1;
            else if (mPhase == 1 && p) mPhase = 2;
            else if (mPhase == 2 && !p) mPhase = 1;
        end
        accOut = acc;
        @(posedge clk_2f);
        #1;
        checkOutput("validout0", 32'(validout0), 32'(mVo[0]));
        checkOutput("validout1", 32'(validout1), 32'(mVo[1]));
        checkOutput("dataout0", 32'(dataout0), 32'(mDo[0]));
        checkOutput("dataout1", 32'(dataout1), 32'(mDo[1]));
        checkOutput("lane_ptr", 32'(lane_ptr), 32'(mPtr));
        checkOutput("err_credit", 32'(err_credit), 32'(mErr));
    endtask

    initial begin
        bit            acc;
        logic [DW-1:0] word;

        reset = 1'b1; valid = 1'b0; data_in = '0; mode = 1'b0;
        pause = 1'b0; credit_ret0 = 1'b0; credit_ret1 = 1'b0;
        @(posedge clk_2f);
        @(posedge clk_2f);
        #1;
        modelReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);

        // Continuous valid in strict mode, no returns: 8 words then stall.
        word = 4'd1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, word, 0, 0, 0, 0, acc);
            if (acc) word = word + 1'b1;
        end
        checkOutput("stall_after_8", 32'(word), 32'd9);

        // Refill lane0 only, send one word, then lane1 starves until one return.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, acc);
        applyStimulus(0, 1, 4'h5, 0, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'h6, 0, 0, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
        applyStimulus(0, 1, 4'h7, 0, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'h8, 0, 0, 0, 0, acc);

        // Work-conserving mode with lane1 empty.
        applyStimulus(0, 0, 0, 1, 0, 1, 0, acc);
        applyStimulus(0, 1, 4'hA, 1, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'hB, 1, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'hC, 1, 0, 0, 0, acc);

        // Pause with valid held high, then resume.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, acc);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, acc);
        applyStimulus(0, 1, 4'h3, 0, 1, 0, 0, acc);
        applyStimulus(0, 1, 4'h4, 0, 1, 0, 0, acc);
        applyStimulus(0, 1, 4'h9, 0, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'hD, 0, 0, 0, 0, acc);

        // Return at full credit sets the sticky flag; return plus acceptance does not.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'hE, 0, 0, 1, 0, acc);

        // Reset landing on an acceptance edge drops the word.
        applyStimulus(0, 1, 4'hF, 0, 0, 0, 0, acc);
        applyStimulus(1, 1, 4'h2, 0, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'h1, 0, 0, 0, 0, acc);
        applyStimulus(0, 1, 4'h1, 0, 0, 0, 0, acc);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(149) == 0, $urandom_range(3) != 0,
                          DW'($urandom_range(15)), $urandom_range(1) == 1,
                          $urandom_range(7) == 0, $urandom_range(2) == 0,
                          $urandom_range(2) == 0, acc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
